// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start, DATA_BITS data (LSB first), optional parity, stop.
// Define UART_RX_PARITY_EN to add the parity bit and parity_err checking.
module uart_rx_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int OS_RATE    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] OS_HALF = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] OS_LAST = CW'(OS_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        os_cnt_q, os_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 pmis_q, pmis_d;
    logic                 ovr_q, ovr_d;
    logic                 complete;

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        armed_d   = armed_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        pmis_d    = pmis_q;
        ovr_d     = 1'b0;
        complete  = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end

        if (os_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    // A start needs a preceding high sample, so a held break
                    // cannot retrigger endlessly.
                    if (!rx_in && armed_q) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                        armed_d  = 1'b0;
                    end else if (rx_in) begin
                        armed_d = 1'b1;
                    end
                end
                S_START: begin
                    if (os_cnt_q == OS_HALF) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        if (!rx_in) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                            armed_d = 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d  = {rx_in, shift_q[DATA_BITS-1:1]};
                        os_cnt_d = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (os_cnt_q == OS_LAST) begin
                        pmis_d   = ((^shift_q) ^ rx_in) != (PARITY_ODD != 0);
                        os_cnt_d = '0;
                        state_d  = S_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        complete = 1'b1;
                        os_cnt_d = '0;
                        state_d  = S_IDLE;
                        armed_d  = rx_in;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end

        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = ~rx_in;
`ifdef UART_RX_PARITY_EN
                perr_d  = pmis_q;
`else
                perr_d  = 1'b0;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            pmis_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            pmis_q    <= pmis_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
    logic unused_parity;
    assign unused_parity = perr_q ^ pmis_q ^ (PARITY_ODD != 0);
`endif

endmodule
